// File: rtl/lfsr_gen.sv
// Purpose: Fibonacci LFSR with loadable seed, period tracking (wrap) and lockup-seed rejection.
// Latency: all outputs are registered; a load or step shows on the outputs one cycle after the edge that takes it.
// Backpressure: none; the block steps only when enable=1 and never stalls its source.
module lfsr_gen #(
    parameter int unsigned     WIDTH   = 10,
    parameter logic [WIDTH-1:0] TAPS   = 10'h240,
    parameter logic [WIDTH-1:0] SEED   = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter bit              XNOR_FB = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] step_count,
    output logic             wrap,
    output logic             lockup_err
);

    // The one state the feedback function maps onto itself: all-ones for
    // XNOR feedback, all-zeros for XOR feedback. It must never be entered.
    localparam logic [WIDTH-1:0] LOCKUP = XNOR_FB ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    // Architectural state. start_q is the point the sequence is measured
    // from; it only moves on reset or load, never on a step.
    logic [WIDTH-1:0] lfsr_q,  lfsr_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic             wrap_q,  wrap_d;
    logic             lock_q,  lock_d;

    // Stepping datapath, kept separate from the control decisions below.
    logic             fb;
    logic [WIDTH-1:0] lfsr_step;
    logic             seed_is_lockup;

    // Feedback bit and one-step successor of the current state.
    always_comb begin
        fb        = (^(lfsr_q & TAPS)) ^ XNOR_FB;
        lfsr_step = {lfsr_q[WIDTH-2:0], fb};
    end

    // A load of the lockup value is illegal and gets replaced by SEED.
    always_comb begin
        seed_is_lockup = (seed_in == LOCKUP);
    end

    // Next-state selection: load beats enable; idle cycles hold everything
    // and let the single-cycle pulses fall back to zero.
    always_comb begin
        lfsr_d  = lfsr_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        lock_d  = 1'b0;

        if (load) begin
            cnt_d = {WIDTH{1'b0}};
            if (seed_is_lockup) begin
                lfsr_d  = SEED;
                start_d = SEED;
                lock_d  = 1'b1;
            end else begin
                lfsr_d  = seed_in;
                start_d = seed_in;
            end
        end else if (enable) begin
            lfsr_d = lfsr_step;
            if (lfsr_step == start_q) begin
                // Returned to the start point: one full period has elapsed.
                cnt_d  = {WIDTH{1'b0}};
                wrap_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + ONE;
            end
        end
    end

    // State register with synchronous active-low reset to SEED.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_q  <= SEED;
            start_q <= SEED;
            cnt_q   <= {WIDTH{1'b0}};
            wrap_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            lock_q  <= lock_d;
        end
    end

    // Outputs come straight from flops; no input reaches an output combinationally.
    assign q          = lfsr_q;
    assign step_count = cnt_q;
    assign wrap       = wrap_q;
    assign lockup_err = lock_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Purpose: directed self-checking bench for lfsr_gen (10-bit XNOR default and 4-bit XOR variant).
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: none; stimulus is driven cycle by cycle.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       reset, enable, load;
    logic [9:0] seed_in;
    logic [9:0] q, step_count;
    logic       wrap, lockup_err;

    logic       s_reset, s_enable, s_load;
    logic [3:0] s_seed;
    logic [3:0] s_q, s_step_count;
    logic       s_wrap, s_lockup_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .seed_in    (seed_in),
        .q          (q),
        .step_count (step_count),
        .wrap       (wrap),
        .lockup_err (lockup_err)
    );

    lfsr_gen #(
        .WIDTH   (4),
        .TAPS    (4'hC),
        .SEED    (4'h1),
        .XNOR_FB (1'b0)
    ) dut_small (
        .clk        (clk),
        .reset      (s_reset),
        .enable     (s_enable),
        .load       (s_load),
        .seed_in    (s_seed),
        .q          (s_q),
        .step_count (s_step_count),
        .wrap       (s_wrap),
        .lockup_err (s_lockup_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs 1023 enabled steps on the 10-bit DUT and checks period properties.
    task automatic run_period10(input string pfx, input logic [9:0] exp_start);
        bit seen [0:1023];
        int first_wrap = -1;
        int nwraps     = 0;
        int distinct   = 0;
        int peak       = 0;
        int n_lock     = 0;
        int hit_lockup = 0;
        logic [9:0] wrap_q  = '0;
        logic [9:0] wrap_sc = '1;
        for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
        enable = 1'b1;
        load   = 1'b0;
        for (int i = 1; i <= 1023; i++) begin
            tick();
            if (!seen[q]) distinct++;
            seen[q] = 1'b1;
            if (q == 10'h3FF) hit_lockup++;
            if (int'(step_count) > peak) peak = int'(step_count);
            if (lockup_err) n_lock++;
            if (wrap) begin
                nwraps++;
                if (first_wrap < 0) begin
                    first_wrap = i;
                    wrap_q     = q;
                    wrap_sc    = step_count;
                end
            end
        end
        enable = 1'b0;
        check_eq({pfx, "_first_wrap_step"}, first_wrap, 1023);
        check_eq({pfx, "_wrap_count"},      nwraps,     1);
        check_eq({pfx, "_q_at_wrap"},       wrap_q,     exp_start);
        check_eq({pfx, "_cnt_at_wrap"},     wrap_sc,    0);
        check_eq({pfx, "_distinct_q"},      distinct,   1023);
        check_eq({pfx, "_lockup_visits"},   hit_lockup, 0);
        check_eq({pfx, "_cnt_peak"},        peak,       1022);
        check_eq({pfx, "_lockup_err_seen"}, n_lock,     0);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; load = 1'b0; seed_in = '0;
        s_reset = 1'b0; s_enable = 1'b0; s_load = 1'b0; s_seed = '0;

        // Reset state, with enable and load also asserted to show reset wins.
        enable = 1'b1; load = 1'b1; seed_in = 10'h155;
        tick(); tick();
        check_eq("rst_q",    q,          10'h001);
        check_eq("rst_cnt",  step_count, 0);
        check_eq("rst_wrap", wrap,       0);
        check_eq("rst_lerr", lockup_err, 0);

        // First steps after reset: 001 -> 003 -> 007.
        load = 1'b0; reset = 1'b1; enable = 1'b1;
        tick();
        check_eq("step1_q",   q,          10'h003);
        check_eq("step1_cnt", step_count, 1);
        tick();
        check_eq("step2_q",   q,          10'h007);
        check_eq("step2_cnt", step_count, 2);

        // Hold with enable low: nothing moves.
        enable = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_eq("hold_q",    q,          10'h007);
        check_eq("hold_cnt",  step_count, 2);
        check_eq("hold_wrap", wrap,       0);

        // Reset mid-sequence discards state, no pulses.
        reset = 1'b0;
        tick();
        check_eq("midrst_q",    q,          10'h001);
        check_eq("midrst_cnt",  step_count, 0);
        check_eq("midrst_wrap", wrap,       0);
        check_eq("midrst_lerr", lockup_err, 0);
        reset = 1'b1;

        // Full period from SEED.
        run_period10("seed", 10'h001);

        // Load with enable: load only, no step.
        load = 1'b1; enable = 1'b1; seed_in = 10'h155;
        tick();
        check_eq("ld155_q",    q,          10'h155);
        check_eq("ld155_cnt",  step_count, 0);
        check_eq("ld155_wrap", wrap,       0);
        check_eq("ld155_lerr", lockup_err, 0);
        load = 1'b0;
        // 155: bit9=0, bit6=1 -> xnor fb=0 -> 2AA.
        tick();
        check_eq("ld155_step_q",   q,          10'h2AA);
        check_eq("ld155_step_cnt", step_count, 1);
        // Reload and measure a full period from the new start point.
        load = 1'b1; seed_in = 10'h155;
        tick();
        load = 1'b0;
        run_period10("ld155", 10'h155);

        // Illegal load of the lockup value.
        load = 1'b1; seed_in = 10'h3FF;
        tick();
        check_eq("lock_q",    q,          10'h001);
        check_eq("lock_lerr", lockup_err, 1);
        check_eq("lock_cnt",  step_count, 0);
        check_eq("lock_wrap", wrap,       0);
        load = 1'b0;
        tick();
        check_eq("lock_lerr_drop", lockup_err, 0);
        check_eq("lock_q_hold",    q,          10'h001);

        // 4-bit XOR variant: hand-traced first steps 1 -> 2 -> 4 -> 9.
        s_reset = 1'b1; s_enable = 1'b1;
        tick();
        check_eq("s_step1_q", s_q, 4'h2);
        tick();
        tick();
        check_eq("s_step3_q",   s_q,          4'h9);
        check_eq("s_step3_cnt", s_step_count, 3);
        s_reset = 1'b0;
        tick();
        s_reset = 1'b1;
        begin
            int nw = 0, w1 = -1, w2 = -1, zero_hits = 0, lerr = 0;
            for (int i = 1; i <= 30; i++) begin
                tick();
                if (s_q == 4'h0) zero_hits++;
                if (s_lockup_err) lerr++;
                if (s_wrap) begin
                    nw++;
                    if (w1 < 0) w1 = i; else w2 = i;
                    check_eq("s_q_at_wrap",   s_q,          4'h1);
                    check_eq("s_cnt_at_wrap", s_step_count, 0);
                end
            end
            check_eq("s_wrap_count", nw,        2);
            check_eq("s_first_wrap", w1,        15);
            check_eq("s_second_wrap", w2,       30);
            check_eq("s_zero_visits", zero_hits, 0);
            check_eq("s_lerr_seen",  lerr,      0);
        end
        s_enable = 1'b0;
        s_load = 1'b1; s_seed = 4'h0;
        tick();
        check_eq("s_lock_lerr", s_lockup_err, 1);
        check_eq("s_lock_q",    s_q,          4'h1);
        check_eq("s_lock_cnt",  s_step_count, 0);
        s_load = 1'b0;
        tick();
        check_eq("s_lock_drop", s_lockup_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
